// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage; returns {remainder, quotient}.
// Optional feature: define DIV_EARLY_OUT_EN to finish immediately when |a| < |b|.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic               cancel,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_request
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_BY_ZERO = 2'b01;
    localparam logic [1:0] S_ON      = 2'b10;
    localparam logic [1:0] S_END     = 2'b11;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_trial;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quot_fix;

    assign result        = r_result;
    assign ready         = r_ready;
    assign stall_request = start & ~r_ready & ~cancel & ~reset;

    // Operand magnitudes for the accepting edge
    always_comb begin
        w_a_neg = signed_div & operand_a[WIDTH-1];
        w_b_neg = signed_div & operand_b[WIDTH-1];
        if (w_a_neg) begin
            w_a_abs = {WIDTH{1'b0}} - operand_a;
        end else begin
            w_a_abs = operand_a;
        end
        if (w_b_neg) begin
            w_b_abs = {WIDTH{1'b0}} - operand_b;
        end else begin
            w_b_abs = operand_b;
        end
    end

    // One restoring step; the trial's top bit is its sign since it never exceeds the divisor
    always_comb begin
        w_trial = {r_rem, r_dividend[WIDTH-1]} - {1'b0, r_divisor};
        w_qbit  = ~w_trial[WIDTH];
        if (w_qbit) begin
            w_rem_next = w_trial[WIDTH-1:0];
        end else begin
            w_rem_next = {r_rem[WIDTH-2:0], r_dividend[WIDTH-1]};
        end
        w_quot_next = {r_quot[WIDTH-2:0], w_qbit};
        if (r_neg_q) begin
            w_quot_fix = {WIDTH{1'b0}} - w_quot_next;
        end else begin
            w_quot_fix = w_quot_next;
        end
        if (r_neg_r) begin
            w_rem_fix = {WIDTH{1'b0}} - w_rem_next;
        end else begin
            w_rem_fix = w_rem_next;
        end
    end

    // Control FSM and datapath registers; cancel overrides start and completion
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= {CW{1'b0}};
            r_dividend <= {WIDTH{1'b0}};
            r_divisor  <= {WIDTH{1'b0}};
            r_rem      <= {WIDTH{1'b0}};
            r_quot     <= {WIDTH{1'b0}};
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_result   <= {(2*WIDTH){1'b0}};
            r_ready    <= 1'b0;
        end else if (cancel) begin
            r_state  <= S_IDLE;
            r_count  <= {CW{1'b0}};
            r_result <= {(2*WIDTH){1'b0}};
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (operand_b == {WIDTH{1'b0}}) begin
                            r_state <= S_BY_ZERO;
`ifdef DIV_EARLY_OUT_EN
                        end else if (w_a_abs < w_b_abs) begin
                            r_state  <= S_END;
                            r_result <= {operand_a, {WIDTH{1'b0}}};
                            r_ready  <= 1'b1;
`endif
                        end else begin
                            r_state    <= S_ON;
                            r_dividend <= w_a_abs;
                            r_divisor  <= w_b_abs;
                            r_rem      <= {WIDTH{1'b0}};
                            r_quot     <= {WIDTH{1'b0}};
                            r_neg_q    <= w_a_neg ^ w_b_neg;
                            r_neg_r    <= w_a_neg;
                            r_count    <= {CW{1'b0}};
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BY_ZERO: begin
                    r_result <= {(2*WIDTH){1'b0}};
                    if (start) begin
                        r_state <= S_END;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                    end
                end
                S_ON: begin
                    if (!start) begin
                        r_state  <= S_IDLE;
                        r_count  <= {CW{1'b0}};
                        r_result <= {(2*WIDTH){1'b0}};
                        r_ready  <= 1'b0;
                    end else begin
                        r_rem      <= w_rem_next;
                        r_quot     <= w_quot_next;
                        r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
                        r_count    <= r_count + {{(CW-1){1'b0}}, 1'b1};
                        if (r_count == CW'(WIDTH - 1)) begin
                            r_state  <= S_END;
                            r_result <= {w_rem_fix, w_quot_fix};
                            r_ready  <= 1'b1;
                        end else begin
                            r_state <= S_ON;
                        end
                    end
                end
                S_END: begin
                    if (!start) begin
                        r_state  <= S_IDLE;
                        r_count  <= {CW{1'b0}};
                        r_result <= {(2*WIDTH){1'b0}};
                        r_ready  <= 1'b0;
                    end else begin
                        r_state <= S_END;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_result <= {(2*WIDTH){1'b0}};
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard testbench for div_unit: stimulus pushes expected {result, ready cycle}; a monitor pops on ready.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic        cancel = 1'b0;
    logic [63:0] result;
    logic        ready;
    logic        stall_request;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] exp_res_q[$];
    int          exp_cyc_q[$];

    div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .signed_div(signed_div),
        .operand_a(operand_a), .operand_b(operand_b), .cancel(cancel),
        .result(result), .ready(ready), .stall_request(stall_request)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, C-style truncation, remainder carries dividend sign
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        if (b == 32'd0) return 2;
        ma = s ? longint'($signed(a)) : longint'({32'd0, a});
        mb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Full divide with handshake; operands are scrambled after the accepting edge
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] er;
        bit got;
        @(negedge clock);
        start = 1'b1; signed_div = s; operand_a = a; operand_b = b;
        er = ref_div(s, a, b);
        exp_res_q.push_back(er);
        exp_cyc_q.push_back(cyc + ref_lat(s, a, b));
        #1 check("stall_on_start", {63'd0, stall_request}, 64'd1);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i == 0) begin
                operand_a = $urandom; operand_b = $urandom; signed_div = ~s;
            end
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("ready_timeout", 64'd0, 64'd1);
            if (exp_res_q.size() > 0) begin
                void'(exp_res_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end else begin
            check("stall_after_ready", {63'd0, stall_request}, 64'd0);
            @(negedge clock);
            check("result_held", result, er);
        end
        start = 1'b0;
        @(negedge clock);
        check("idle_ready", {63'd0, ready}, 64'd0);
        check("idle_result", result, 64'd0);
    endtask

    // Monitor: compare each rising ready against the scoreboard head
    initial begin
        logic prev_ready;
        logic [63:0] er;
        int ec;
        prev_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (ready && !prev_ready) begin
                if (exp_res_q.size() == 0) begin
                    check("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    er = exp_res_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("result", result, er);
                    check("latency_cycle", 64'(ec), 64'(cyc));
                end
            end
            prev_ready = ready;
        end
    end

    initial begin
        logic s;
        logic [31:0] a, b;
        start = 1'b1;
        #12;
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_stall", {63'd0, stall_request}, 64'd0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        do_div(1'b0, 32'd100, 32'd7);
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7);
        do_div(1'b1, 32'd100, 32'hFFFF_FFF9);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div(1'b0, 32'd5, 32'd0);
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0);
        do_div(1'b0, 32'd5, 32'd9);
        do_div(1'b1, 32'hFFFF_FFFB, 32'd9);
        do_div(1'b0, 32'd0, 32'd3);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1);
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Cancel at iteration 10, then a fresh divide
        @(negedge clock);
        start = 1'b1; signed_div = 1'b0; operand_a = 32'd1000; operand_b = 32'd3;
        repeat (10) @(negedge clock);
        cancel = 1'b1;
        #1 check("stall_on_cancel", {63'd0, stall_request}, 64'd0);
        @(negedge clock);
        check("cancel_ready", {63'd0, ready}, 64'd0);
        cancel = 1'b0; start = 1'b0;
        do_div(1'b0, 32'd100, 32'd7);

        // Start dropped mid-divide is an abort
        @(negedge clock);
        start = 1'b1; operand_a = 32'd12345; operand_b = 32'd11;
        repeat (5) @(negedge clock);
        start = 1'b0;
        repeat (40) @(negedge clock);
        check("abort_ready", {63'd0, ready}, 64'd0);

        // Async reset mid-divide
        @(negedge clock);
        start = 1'b1; operand_a = 32'd999; operand_b = 32'd4;
        repeat (6) @(negedge clock);
        #2 reset = 1'b1;
        #1 check("areset_on_ready", {63'd0, ready}, 64'd0);
        start = 1'b0;
        #1 reset = 1'b0;
        repeat (40) @(negedge clock);
        check("areset_on_quiet", {63'd0, ready}, 64'd0);

        // Async reset while a result is held
        @(negedge clock);
        start = 1'b1; signed_div = 1'b0; operand_a = 32'd77; operand_b = 32'd5;
        exp_res_q.push_back(ref_div(1'b0, 32'd77, 32'd5));
        exp_cyc_q.push_back(cyc + ref_lat(1'b0, 32'd77, 32'd5));
        repeat (34) @(negedge clock);
        check("end_ready", {63'd0, ready}, 64'd1);
        #2 reset = 1'b1;
        #1 check("areset_end_result", result, 64'd0);
        check("areset_end_ready", {63'd0, ready}, 64'd0);
        start = 1'b0;
        #1 reset = 1'b0;
        if (exp_res_q.size() > 0) begin
            check("end_not_seen", 64'(exp_res_q.size()), 64'd0);
            exp_res_q.delete();
            exp_cyc_q.delete();
        end

        for (int k = 0; k < 40; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = a + 32'd1;
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            do_div(s, a, b);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 64'(exp_res_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
